// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives PC to instruction memory and registers fetched
// words into IF/ID, with a one-entry skid buffer to absorb downstream stalls.
module fetch_unit (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        LE,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] IFID_instr,
  output logic [7:0]  IFID_next_pc,
  output logic        IFID_valid
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  pc_reg, pc_next;
  logic [31:0] skid_instr_reg, skid_instr_next;
  logic [7:0]  skid_npc_reg, skid_npc_next;
  logic [31:0] ifid_instr_reg, ifid_instr_next;
  logic [7:0]  ifid_npc_reg, ifid_npc_next;
  logic        ifid_valid_reg, ifid_valid_next;
  logic [7:0]  pc_plus4;

  // 8-bit wrap is intentional: 0xFC + 4 rolls over to 0x00.
  assign pc_plus4 = pc_reg + 8'd4;

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_reg      <= FETCH;
      pc_reg         <= 8'h00;
      skid_instr_reg <= 32'h0;
      skid_npc_reg   <= 8'h00;
      ifid_instr_reg <= 32'h0;
      ifid_npc_reg   <= 8'h00;
      ifid_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      skid_instr_reg <= skid_instr_next;
      skid_npc_reg   <= skid_npc_next;
      ifid_instr_reg <= ifid_instr_next;
      ifid_npc_reg   <= ifid_npc_next;
      ifid_valid_reg <= ifid_valid_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    skid_instr_next = skid_instr_reg;
    skid_npc_next   = skid_npc_reg;
    ifid_instr_next = ifid_instr_reg;
    ifid_npc_next   = ifid_npc_reg;
    ifid_valid_next = ifid_valid_reg;

    if (branch_taken) begin
      // Redirect overrides stalls, buffered words and any same-cycle response.
      state_next      = FETCH;
      pc_next         = {branch_target[7:2], 2'b00};
      skid_instr_next = 32'h0;
      skid_npc_next   = 8'h00;
      ifid_instr_next = 32'h0;
      ifid_npc_next   = 8'h00;
      ifid_valid_next = 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (imem_ready) begin
            if (LE) begin
              ifid_instr_next = imem_rdata;
              ifid_npc_next   = pc_plus4;
              ifid_valid_next = 1'b1;
              pc_next         = pc_plus4;
            end else begin
              skid_instr_next = imem_rdata;
              skid_npc_next   = pc_plus4;
              state_next      = HOLD;
            end
          end else if (LE) begin
            ifid_instr_next = 32'h0;
            ifid_npc_next   = 8'h00;
            ifid_valid_next = 1'b0;
          end
        end
        HOLD: begin
          if (LE) begin
            ifid_instr_next = skid_instr_reg;
            ifid_npc_next   = skid_npc_reg;
            ifid_valid_next = 1'b1;
            pc_next         = pc_plus4;
            state_next      = FETCH;
          end
        end
        default: state_next = FETCH;
      endcase
    end
  end

  assign imem_req     = (state_reg == FETCH);
  assign imem_addr    = pc_reg;
  assign IFID_instr   = ifid_instr_reg;
  assign IFID_next_pc = ifid_npc_reg;
  assign IFID_valid   = ifid_valid_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Clr;
  logic        LE;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] IFID_instr;
  logic [7:0]  IFID_next_pc;
  logic        IFID_valid;
  logic [31:0] junk;

  int total = 0;
  int bad   = 0;
  bit armed = 0;

  fetch_unit dut (
    .Clk(Clk), .Clr(Clr), .LE(LE), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .IFID_instr(IFID_instr),
    .IFID_next_pc(IFID_next_pc), .IFID_valid(IFID_valid)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] tag(input logic [7:0] a);
    return {a, 8'hA5, ~a, a ^ 8'h3C};
  endfunction

  assign imem_rdata = imem_ready ? tag(imem_addr) : junk;

  // Reference model: "holding" simply means a fetched word is waiting in the queue.
  typedef struct packed {logic [31:0] instr; logic [7:0] npc;} word_t;
  word_t      m_buf[$];
  logic [7:0] m_pc    = 8'h00;
  word_t      m_out   = '0;
  logic       m_valid = 1'b0;

  always @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      m_pc = 8'h00; m_buf.delete(); m_out = '0; m_valid = 1'b0;
    end else if (branch_taken) begin
      m_pc = branch_target & 8'hFC; m_buf.delete(); m_out = '0; m_valid = 1'b0;
    end else if (m_buf.size() != 0) begin
      if (LE) begin
        m_out = m_buf.pop_front(); m_valid = 1'b1; m_pc = m_pc + 8'd4;
      end
    end else if (imem_ready) begin
      if (LE) begin
        m_out = '{instr: tag(m_pc), npc: m_pc + 8'd4}; m_valid = 1'b1;
        m_pc = m_pc + 8'd4;
      end else begin
        m_buf.push_back('{instr: tag(m_pc), npc: m_pc + 8'd4});
      end
    end else if (LE) begin
      m_out = '0; m_valid = 1'b0;
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (armed) begin
      lit("cyc_req",   {31'b0, imem_req},   {31'b0, (m_buf.size() == 0)});
      lit("cyc_addr",  {24'b0, imem_addr},  {24'b0, m_pc});
      lit("cyc_instr", IFID_instr,          m_out.instr);
      lit("cyc_npc",   {24'b0, IFID_next_pc}, {24'b0, m_out.npc});
      lit("cyc_valid", {31'b0, IFID_valid}, {31'b0, m_valid});
    end
  end

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    Clr = 1'b0; LE = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    imem_ready = 1'b0; junk = 32'hDEAD_BEEF;
    step(); step();
    lit("rst_req",   {31'b0, imem_req}, 32'd1);
    lit("rst_addr",  {24'b0, imem_addr}, 32'h0);
    lit("rst_valid", {31'b0, IFID_valid}, 32'd0);
    lit("rst_instr", IFID_instr, 32'h0);
    lit("rst_npc",   {24'b0, IFID_next_pc}, 32'h0);
    armed = 1;

    // Streaming
    Clr = 1'b1; imem_ready = 1'b1; LE = 1'b1;
    step();
    lit("str_npc0",   {24'b0, IFID_next_pc}, 32'h04);
    lit("str_instr0", IFID_instr, tag(8'h00));
    lit("str_valid0", {31'b0, IFID_valid}, 32'd1);
    step();
    lit("str_npc1",   {24'b0, IFID_next_pc}, 32'h08);
    lit("str_addr1",  {24'b0, imem_addr}, 32'h08);

    // Stall on the cycle the word for 0x08 returns
    LE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      lit("stall_req",  {31'b0, imem_req}, 32'd0);
      lit("stall_addr", {24'b0, imem_addr}, 32'h08);
      lit("stall_npc",  {24'b0, IFID_next_pc}, 32'h08);
    end
    LE = 1'b1;
    step();
    lit("unstall_npc",   {24'b0, IFID_next_pc}, 32'h0C);
    lit("unstall_instr", IFID_instr, tag(8'h08));
    lit("unstall_addr",  {24'b0, imem_addr}, 32'h0C);

    // Slow memory
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      lit("slow_valid", {31'b0, IFID_valid}, 32'd0);
      lit("slow_instr", IFID_instr, 32'h0);
      lit("slow_addr",  {24'b0, imem_addr}, 32'h0C);
    end
    imem_ready = 1'b1;
    step();
    lit("slow_npc",   {24'b0, IFID_next_pc}, 32'h10);
    lit("slow_instr2", IFID_instr, tag(8'h0C));

    // Redirect while holding a buffered word
    LE = 1'b0;
    step();
    lit("hold_req", {31'b0, imem_req}, 32'd0);
    branch_taken = 1'b1; branch_target = 8'h43;
    step();
    lit("br_addr",  {24'b0, imem_addr}, 32'h40);
    lit("br_valid", {31'b0, IFID_valid}, 32'd0);
    lit("br_req",   {31'b0, imem_req}, 32'd1);
    branch_taken = 1'b0; LE = 1'b1;
    step();
    lit("br_npc",   {24'b0, IFID_next_pc}, 32'h44);
    lit("br_instr", IFID_instr, tag(8'h40));

    // Wrap at the top of the address space
    branch_taken = 1'b1; branch_target = 8'hFE;
    step();
    lit("wrap_addr0", {24'b0, imem_addr}, 32'hFC);
    branch_taken = 1'b0;
    step();
    lit("wrap_npc",   {24'b0, IFID_next_pc}, 32'h00);
    lit("wrap_addr",  {24'b0, imem_addr}, 32'h00);
    lit("wrap_instr", IFID_instr, tag(8'hFC));

    // Asynchronous reset while in HOLD, between clock edges
    LE = 1'b0;
    step(); step();
    lit("ar_hold_req", {31'b0, imem_req}, 32'd0);
    Clr = 1'b0;
    #1;
    lit("ar_req",   {31'b0, imem_req}, 32'd1);
    lit("ar_addr",  {24'b0, imem_addr}, 32'h00);
    lit("ar_valid", {31'b0, IFID_valid}, 32'd0);
    lit("ar_npc",   {24'b0, IFID_next_pc}, 32'h00);
    #1;
    Clr = 1'b1; LE = 1'b1; imem_ready = 1'b1;
    step();
    lit("ar_first_npc",   {24'b0, IFID_next_pc}, 32'h04);
    lit("ar_first_instr", IFID_instr, tag(8'h00));

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        Clr = 1'b0;
        #1;
        Clr = 1'b1;
      end
      LE            = ($urandom_range(0, 3) != 0);
      imem_ready    = ($urandom_range(0, 3) != 0);
      branch_taken  = ($urandom_range(0, 15) == 0);
      branch_target = 8'($urandom_range(0, 255));
      junk          = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-low.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Clr  input  1  asynchronous active-low reset; Clr=0 forces reset state immediately, independent of Clk.
REQ-004 LE  input  1  downstream load enable; 1 = ID accepts a new IF/ID entry this cycle, 0 = stall.
REQ-005 branch_taken  input  1  redirect request from ID stage.
REQ-006 branch_target  input  8  redirect byte address; bits [1:0] SHALL be ignored and treated as 00.
REQ-007 imem_req  output  1  fetch request to instruction memory.
REQ-008 imem_addr  output  8  fetch byte address, equal to PC.
REQ-009 imem_rdata  input  32  instruction word, valid only when imem_ready=1.
REQ-010 imem_ready  input  1  memory response strobe; multi-cycle latency allowed.
REQ-011 IFID_instr  output  32  registered instruction to ID.
REQ-012 IFID_next_pc  output  8  registered PC+4 of the fetched instruction.
REQ-013 IFID_valid  output  1  1 = IFID_instr is a real instruction, 0 = bubble.

Function
REQ-014 PC SHALL be an 8-bit register; imem_addr SHALL equal PC combinationally.
REQ-015 PC+4 SHALL be 8-bit modulo: 0xFC+4 = 0x00, with no carry out and no error.
REQ-016 FSM states SHALL be FETCH and HOLD; imem_req SHALL be 1 in FETCH and 0 in HOLD.
REQ-017 FETCH, imem_ready=1, LE=1 SHALL load IF/ID with {imem_rdata, PC+4, valid=1}, set PC to PC+4, and stay in FETCH.
REQ-018 FETCH, imem_ready=1, LE=0 SHALL capture imem_rdata and PC+4 into a one-entry skid buffer, hold PC and IF/ID, and go to HOLD.
REQ-019 FETCH, imem_ready=0, LE=1 SHALL load IF/ID with a bubble {0x00000000, 0x00, valid=0} and hold PC.
REQ-020 FETCH, imem_ready=0, LE=0 SHALL hold PC, IF/ID and state.
REQ-021 In HOLD, imem_ready SHALL be ignored.
REQ-022 HOLD, LE=1 SHALL load IF/ID from the skid buffer with valid=1, set PC to PC+4, and go to FETCH.
REQ-023 HOLD, LE=0 SHALL hold everything.
REQ-024 branch_taken=1 SHALL take priority over all other conditions, including LE=0 and HOLD. On the next edge it SHALL:
- set PC = {branch_target[7:2],2'b00};
- flush IF/ID to a bubble;
- discard the skid buffer and any same-cycle imem response;
- enter FETCH.
REQ-025 Throughput SHALL be one instruction per cycle when imem_ready=1 every cycle and LE=1; latency from response to IF/ID output is 1 cycle.
REQ-026 No instruction SHALL be lost or duplicated across any stall sequence.

Reset
REQ-027 While Clr=0, the block SHALL hold:
- PC=0x00, state=FETCH, skid buffer cleared;
- IFID_instr=0x00000000, IFID_next_pc=0x00, IFID_valid=0;
- imem_req=1, imem_addr=0x00.
REQ-028 Clr asserted mid-stall or mid-redirect SHALL abandon the operation; the first fetch after release SHALL be from address 0x00.

Verification
REQ-029 Streaming: release reset, imem_ready=1, LE=1, rdata = addr-tagged words -> IFID_next_pc 0x04, 0x08, 0x0C on consecutive cycles, all valid=1.
REQ-030 Stall with response: LE=0 on the cycle the word for 0x08 returns, held 3 cycles -> PC stays 0x08, imem_req=0 in HOLD, and the word appears once when LE=1 with IFID_next_pc=0x0C.
REQ-031 Slow memory: imem_ready=0 for 2 cycles with LE=1 -> two bubbles (valid=0, instr=0), PC unchanged, then normal load.
REQ-032 Redirect during HOLD: branch_taken=1, branch_target=0x43 -> PC=0x40, IF/ID bubble, buffered word never emitted, FETCH from 0x40.
REQ-033 Wrap: PC=0xFC fetched -> IFID_next_pc=0x00 and next imem_addr=0x00.
REQ-034 Async reset: drop Clr between clock edges while in HOLD -> outputs reach reset values without a Clk edge; first fetch after release is from 0x00.
